// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : 4-bit operation codes driven on the op port
//   - mdu_state_e : control FSM encoding (IDLE, MUL, DIV)
//   - is_mul_op / is_div_op / is_signed_op : op-code classification helpers
// Optional feature macro: MDU_MADD_EN. When defined, MADD/MADDU/MSUB/MSUBU
// classify as multiply-class ops; otherwise they are unknown codes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MTHI  = 4'd4,
    MDU_MTLO  = 4'd5,
    MDU_MADD  = 4'd6,
    MDU_MADDU = 4'd7,
    MDU_MSUB  = 4'd8,
    MDU_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  // Ops that run through the MUL state (MUL_CYCLES latency).
  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Ops that run through the DIV state (WIDTH+1 latency).
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and the MDU.
//   start  : single-cycle request         op     : operation code (mdu_pkg)
//   a, b   : rs / rt operands             cancel : pipeline flush abort
//   busy   : operation in flight          hi, lo : HI/LO register values
// master = EX stage / pipeline side, slave = mdu_iter.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per cycle.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   load      : capture dividend/divisor magnitudes and clear the remainder
//   step      : perform one restoring iteration
//   dividend  : unsigned dividend magnitude
//   divisor   : unsigned divisor magnitude
//   quotient  : valid after WIDTH steps following a load
//   remainder : valid after WIDTH steps following a load
// Signs, divide-by-zero and overflow are resolved by the caller.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvsr_reg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One extra bit so the trial subtraction's borrow lands in diff[WIDTH].
  always_comb begin
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_reg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvsr_reg <= '0;
    end else if (load) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dvsr_reg <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_reg <= diff[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO register pair.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mdu_iter_if.slave (start/op/a/b/cancel in, busy/hi/lo out)
// Multiply completes MUL_CYCLES edges after accept; divide completes WIDTH+1
// edges after accept (WIDTH quotient bits plus a sign-fix edge). MTHI/MTLO
// write in the accept edge. cancel aborts an in-flight op without touching
// HI/LO and also suppresses a simultaneous start.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  localparam int CNT_MAX = ((MUL_CYCLES - 1) > WIDTH) ? (MUL_CYCLES - 1) : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic start_mul, start_div, start_mthi, start_mtlo, done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_mul  = 1'b0;
    start_div  = 1'b0;
    start_mthi = 1'b0;
    start_mtlo = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Starts are only looked at while idle; cancel vetoes them.
        if (bus.start && !bus.cancel) begin
          if (is_mul_op(bus.op)) begin
            start_mul  = 1'b1;
            state_next = MUL;
          end else if (is_div_op(bus.op)) begin
            start_div  = 1'b1;
            state_next = DIV;
          end else if (bus.op == MDU_MTHI) begin
            start_mthi = 1'b1;
          end else if (bus.op == MDU_MTLO) begin
            start_mtlo = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        // Cancel wins over a completion in the same cycle.
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- divider
  logic             in_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] core_q, core_r;

  always_comb begin
    in_signed = is_signed_op(bus.op);
    mag_a     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Steps on the WIDTH edges while the counter is non-zero; the final DIV
  // edge (counter zero) only consumes the result.
  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (start_div),
    .step      ((state_reg == DIV) && (cnt_reg != '0)),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // ---------------------------------------------------------------- results
  logic                 op_signed;
  logic [2*WIDTH-1:0]   ext_a, ext_b, product, mul_result;
  logic [WIDTH-1:0]     div_hi, div_lo;

  always_comb begin
    op_signed  = is_signed_op(op_reg);
    ext_a      = op_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    ext_b      = op_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    product    = ext_a * ext_b;
    mul_result = product;
`ifdef MDU_MADD_EN
    // HI/LO are frozen while busy, so the live pair equals the accept-time pair.
    case (op_reg)
      MDU_MADD, MDU_MADDU: mul_result = {hi_reg, lo_reg} + product;
      MDU_MSUB, MDU_MSUBU: mul_result = {hi_reg, lo_reg} - product;
      default:             mul_result = product;
    endcase
`endif

    // Truncating division: quotient negative when signs differ, remainder
    // follows the dividend.
    div_lo = (op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -core_q : core_q;
    div_hi = (op_signed && a_reg[WIDTH-1]) ? -core_r : core_r;
    if (b_reg == '0) begin
      div_lo = '1;
      div_hi = a_reg;
    end else if (op_signed && (a_reg == MIN_VAL) && (b_reg == '1)) begin
      div_lo = MIN_VAL;
      div_hi = '0;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else begin
      if (start_mul || start_div) begin
        a_reg   <= bus.a;
        b_reg   <= bus.b;
        op_reg  <= bus.op;
        cnt_reg <= start_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(WIDTH);
      end else if (state_reg != IDLE) begin
        cnt_reg <= (bus.cancel || (cnt_reg == '0)) ? '0 : cnt_reg - CNT_W'(1);
      end

      if (start_mthi) hi_reg <= bus.a;
      if (start_mtlo) lo_reg <= bus.a;

      if (done) begin
        if (state_reg == MUL) begin
          hi_reg <= mul_result[2*WIDTH-1:WIDTH];
          lo_reg <= mul_result[WIDTH-1:0];
        end else begin
          hi_reg <= div_hi;
          lo_reg <= div_lo;
        end
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5).
// Expected results are pushed to a scoreboard queue when an operation is
// driven and popped when the unit finishes.
// Optional feature macro: MDU_MADD_EN (enables the accumulate scenario).
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = W + 1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // ------------------------------------------------------------ reference model
  function automatic logic [2*W-1:0] model_mul(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sbv;
    if (op == OP_MULT) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [2*W-1:0] model_div(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int q, r;
    logic [W-1:0] qq, rr;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q  = $signed(a) / $signed(b);
      r  = $signed(a) % $signed(b);
      qq = q;
      rr = r;
      return {rr, qq};
    end
    return {a % b, a / b};
  endfunction

  // ------------------------------------------------------------ helpers
  task automatic write_mt(input logic [3:0] op, input logic [W-1:0] v);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = v; bus.b = '0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat);
    exp_t e;
    logic [W-1:0] hi0, lo0;
    int cyc;
    bit moved;
    e.hi = ehi; e.lo = elo; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    hi0 = bus.hi; lo0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; moved = 1'b0;
    while (bus.busy && cyc < 200) begin
      if (bus.hi !== hi0 || bus.lo !== lo0) moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    total++;
    if (cyc !== e.lat) begin bad++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, e.lat); end
    total++;
    if (bus.hi !== e.hi) begin bad++; $display("FAIL %s hi: got %h, expected %h", name, bus.hi, e.hi); end
    total++;
    if (bus.lo !== e.lo) begin bad++; $display("FAIL %s lo: got %h, expected %h", name, bus.lo, e.lo); end
    total++;
    if (moved) begin bad++; $display("FAIL %s hi/lo moved while busy: got 1, expected 0", name); end
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", name, op, a, b, bus.hi, bus.lo, cyc);
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b, expected 0", bus.busy); end
    total++; if (bus.hi !== '0) begin bad++; $display("FAIL reset hi: got %h, expected 0", bus.hi); end
    total++; if (bus.lo !== '0) begin bad++; $display("FAIL reset lo: got %h, expected 0", bus.lo); end
    $display("txn reset busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MC);
  endtask

  task automatic test_div();
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    run_op("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DC);
  endtask

  task automatic test_div_special();
    run_op("divu_by_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, DC);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
    run_op("div_neg_by_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DC);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] r;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : $urandom;
      if (i == 0) b = 32'hFFFF_FFF5;
      if (op == OP_MULT || op == OP_MULTU) begin
        r = model_mul(op, a, b);
        run_op("rand_mul", op, a, b, r[2*W-1:W], r[W-1:0], MC);
      end else begin
        r = model_div(op, a, b);
        run_op("rand_div", op, a, b, r[2*W-1:W], r[W-1:0], DC);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int cyc;
    e.hi = 32'd0; e.lo = 32'd12; e.lat = MC;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd100; bus.b = 32'd100;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 2;
    while (bus.busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) begin bad++; $display("FAIL ignore_start latency: got %0d, expected %0d", cyc, e.lat); end
    total++; if (bus.hi !== e.hi) begin bad++; $display("FAIL ignore_start hi: got %h, expected %h", bus.hi, e.hi); end
    total++; if (bus.lo !== e.lo) begin bad++; $display("FAIL ignore_start lo: got %h, expected %h", bus.lo, e.lo); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_start restart busy: got %b, expected 0", bus.busy); end
    $display("txn ignore_start hi=%h lo=%h cycles=%0d", bus.hi, bus.lo, cyc);
  endtask

  task automatic test_cancel();
    exp_t e;
    write_mt(OP_MTHI, 32'h1111_1111);
    write_mt(OP_MTLO, 32'h2222_2222);
    e.hi = 32'h1111_1111; e.lo = 32'h2222_2222; e.lat = 0;
    sb.push_back(e);
    // Cancel sampled on the third edge of a DIV.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    e = sb.pop_front();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_div busy: got %b, expected 0", bus.busy); end
    repeat (40) @(negedge clk);
    total++; if (bus.hi !== e.hi) begin bad++; $display("FAIL cancel_div hi: got %h, expected %h", bus.hi, e.hi); end
    total++; if (bus.lo !== e.lo) begin bad++; $display("FAIL cancel_div lo: got %h, expected %h", bus.lo, e.lo); end
    $display("txn cancel_div busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // Cancel in the cycle that would otherwise complete a MULT.
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (MC - 1) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    e = sb.pop_front();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_last busy: got %b, expected 0", bus.busy); end
    total++; if (bus.lo !== e.lo) begin bad++; $display("FAIL cancel_last lo: got %h, expected %h", bus.lo, e.lo); end
    total++; if (bus.hi !== e.hi) begin bad++; $display("FAIL cancel_last hi: got %h, expected %h", bus.hi, e.hi); end
    $display("txn cancel_last busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // Cancel while idle vetoes a simultaneous MTHI and a simultaneous MULT.
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hABCD_ABCD; bus.cancel = 1'b1;
    @(negedge clk);
    bus.op = OP_MULT;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    e = sb.pop_front();
    total++; if (bus.hi !== e.hi) begin bad++; $display("FAIL cancel_idle hi: got %h, expected %h", bus.hi, e.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_idle busy: got %b, expected 0", bus.busy); end
    $display("txn cancel_idle busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
  endtask

  task automatic test_mthi();
    logic [W-1:0] lo0;
    lo0 = bus.lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi hi: got %h, expected deadbeef", bus.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi busy: got %b, expected 0", bus.busy); end
    total++; if (bus.lo !== lo0) begin bad++; $display("FAIL mthi lo: got %h, expected %h", bus.lo, lo0); end
    $display("txn mthi hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'h0BAD_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL mtlo lo: got %h, expected 0badf00d", bus.lo); end
    total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mtlo hi: got %h, expected deadbeef", bus.hi); end
    $display("txn mtlo hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_mid pre busy: got %b, expected 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy: got %b, expected 0", bus.busy); end
    total++; if (bus.hi !== '0) begin bad++; $display("FAIL rst_mid hi: got %h, expected 0", bus.hi); end
    total++; if (bus.lo !== '0) begin bad++; $display("FAIL rst_mid lo: got %h, expected 0", bus.lo); end
    $display("txn rst_mid busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DC);
  endtask

  task automatic test_unknown_op();
    logic [3:0] ops[$];
`ifndef MDU_MADD_EN
    ops.push_back(4'd6);
`endif
    ops.push_back(4'd10);
    ops.push_back(4'd15);
    write_mt(OP_MTHI, 32'h5555_AAAA);
    write_mt(OP_MTLO, 32'h0F0F_F0F0);
    foreach (ops[i]) begin
      @(negedge clk);
      bus.start = 1'b1; bus.op = ops[i]; bus.a = 32'h1; bus.b = 32'h1;
      @(negedge clk);
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL unknown_op%0d busy: got %b, expected 0", ops[i], bus.busy); end
      total++; if (bus.hi !== 32'h5555_AAAA) begin bad++; $display("FAIL unknown_op%0d hi: got %h, expected 5555aaaa", ops[i], bus.hi); end
      total++; if (bus.lo !== 32'h0F0F_F0F0) begin bad++; $display("FAIL unknown_op%0d lo: got %h, expected 0f0ff0f0", ops[i], bus.lo); end
      $display("txn unknown_op op=%0d busy=%b hi=%h lo=%h", ops[i], bus.busy, bus.hi, bus.lo);
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    write_mt(OP_MTHI, 32'h0);
    write_mt(OP_MTLO, 32'hFFFF_FFFF);
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, MC);
    // {1,0} - (-2 * 3) = 0x1_0000_0006
    run_op("msub", OP_MSUB, 32'hFFFF_FFFE, 32'd3, 32'd1, 32'd6, MC);
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_random();
    test_ignore_start();
    test_cancel();
    test_mthi();
    test_rst_mid();
    test_unknown_op();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle datapath's combinational arithmetic: it adds multi-cycle MULT/DIV with a busy handshake, MTHI/MTLO writes, and cancel for pipeline flush.
- Sits beside the ALU in the EX stage; MFHI/MFLO read the hi/lo outputs directly.
- The stall unit holds dependent instructions while busy=1.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 5: multiply latency in cycles. Must be 1 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; sampled on a rising edge
- op  input  4  operation code (mdu_pkg)
- a  input  WIDTH  rs operand
- b  input  WIDTH  rt operand
- cancel  input  1  abort the in-flight operation (flush)
- busy  output  1  operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous): hi=0, lo=0, busy=0, state IDLE, counter=0.
- States: IDLE, MUL, DIV.
  - IDLE→MUL on start with MULT/MULTU (or MADD* under the macro).
  - IDLE→DIV on start with DIV/DIVU.
  - MUL/DIV→IDLE when the counter expires or cancel=1.
- Accept rule: start is accepted only when busy=0. While busy=1, start is ignored and the operands are not latched.
- Latency:
  - Start accepted at edge T0 latches a and b. busy=1 from after T0 through edge T0+N, where it falls.
  - hi/lo update on that same edge T0+N.
  - N=MUL_CYCLES for multiply; N=WIDTH+1 for divide (one quotient bit per cycle plus one sign-fix cycle).
- MTHI/MTLO: write a into hi or lo at the accept edge. busy stays 0.
- Multiply: {hi,lo} = 2*WIDTH-bit product. MULT is signed, MULTU unsigned.
- Divide: lo = quotient, hi = remainder. Truncating division; the remainder takes the sign of the dividend.
- Divide by zero (b=0, signed or unsigned): lo = all ones, hi = a.
- Signed overflow (a=MIN, b=-1): lo = MIN, hi = 0.
- Unknown or disabled op code: no effect, busy stays 0.
- Cancel:
  - cancel=1 with busy=1: busy=0 after the next edge, hi/lo unchanged.
  - cancel has priority over completion in the same cycle.
  - A start in the same cycle as cancel is ignored.
  - cancel with busy=0 has no effect, except that it suppresses a simultaneous start (including MTHI/MTLO).
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- hi/lo never change while busy=1.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, four extra ops are accepted with MUL_CYCLES latency:
  - MADD/MADDU: {hi,lo} += product.
  - MSUB/MSUBU: {hi,lo} -= product.
  - The accumulate is 2*WIDTH-bit modular and uses the {hi,lo} value held at accept time.
- When undefined, these codes are treated as unknown (no effect).

Decomposition:
- mdu_pkg holds:
  - op codes: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MADD=6, MDU_MADDU=7, MDU_MSUB=8, MDU_MSUBU=9
  - state encoding: IDLE, MUL, DIV
- One sub-module: mdu_div_core.
  - Unsigned restoring divider, one bit per cycle.
  - Handles magnitudes only; the top handles signs and the zero/overflow cases.
- The multiplier is a behavioural product held in a MUL_CYCLES-deep delay counter.

Test Plan (WIDTH=32, MUL_CYCLES=5):
- MULT a=0xFFFFFFFE(-2), b=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → busy for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- MULT started, second MULT pulsed at cycle 2 → second ignored; result matches the first only. cancel at cycle 3 of a DIV → busy=0 next edge, hi/lo keep prior values.
- MTHI a=0xDEADBEEF → hi updates at the next edge, busy stays 0. Assert rst mid-DIV → hi=lo=0, busy=0 immediately.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0. Without the macro, op=6 → no change, busy=0.
